// File: rtl/gigatron_pkg.sv
// Shared definitions for the gigatron memory arbiter: slot numbering, slot kinds
// and the helper that classifies a clock within the instruction window.
package gigatron_pkg;

    localparam int SLOT_CPU_RD = 0;
    localparam int SLOT_CPU_WR = 1;
    localparam int AW_DEFAULT  = 16;

    typedef enum logic [1:0] {
        CPU_RD,
        CPU_WR,
        HOST
    } slot_type_e;

    // While halted every clock is offered to the host.
    function automatic slot_type_e slot_kind(input int slot, input logic halted);
        if (halted)
            return HOST;
        if (slot == SLOT_CPU_RD)
            return CPU_RD;
        if (slot == SLOT_CPU_WR)
            return CPU_WR;
        return HOST;
    endfunction

endpackage

// File: rtl/gigatron_slot_timer.sv
// Free-running slot counter for the CPU instruction window, cpu_ce generation
// and the halt register that only changes at a window boundary.
module gigatron_slot_timer
    import gigatron_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int SW    = 2
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic          host_hold,
    output logic [SW-1:0] slot,
    output logic          halted,
    output logic          cpu_ce
);

    localparam logic [SW-1:0] LAST = SW'(SLOTS - 1);

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            slot   <= '0;
            halted <= 1'b0;
        end else begin
            slot <= (slot == LAST) ? '0 : slot + SW'(1);
            // Sampled together with cpu_ce so an instruction is never split.
            if (slot == LAST)
                halted <= host_hold;
        end
    end

    assign cpu_ce = rst_n && !halted && (slot == LAST);

endmodule

// File: rtl/gigatron_mem_arbiter.sv
// Time-slices one synchronous single-port RAM between the gigatron CPU and a
// host requester; CPU read/write slots come first, remaining slots go to the host.
module gigatron_mem_arbiter
    import gigatron_pkg::*;
#(
    parameter int SLOTS = 4,
    parameter int AW    = AW_DEFAULT
) (
    input  logic          clock,
    input  logic          rst_n,
    input  logic [AW-1:0] cpu_addr_r,
    input  logic [AW-1:0] cpu_addr_w,
    input  logic [7:0]    cpu_data_o,
    input  logic          cpu_we,
    output logic [7:0]    cpu_data_i,
    output logic          cpu_ce,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [7:0]    host_wdata,
    output logic          host_ack,
    output logic [7:0]    host_rdata,
    input  logic          host_hold,
    output logic          cpu_halted,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    output logic          ram_we,
    input  logic [7:0]    ram_rdata
);

    localparam int SW = $clog2(SLOTS);

    logic [SW-1:0] slot;
    logic          halted;
    slot_type_e    stype;
    logic          host_issue;
    logic          ack_p1;
    logic          ack_rd_p1;
    logic [7:0]    rdata_p1;

    gigatron_slot_timer #(
        .SLOTS (SLOTS),
        .SW    (SW)
    ) u_slot_timer (
        .clock     (clock),
        .rst_n     (rst_n),
        .host_hold (host_hold),
        .slot      (slot),
        .halted    (halted),
        .cpu_ce    (cpu_ce)
    );

    assign cpu_halted = halted;

    always_comb stype = slot_kind(int'(slot), halted);

    // Port mux; the ack cycle never issues so a held request is served once.
    always_comb begin
        ram_addr   = '0;
        ram_wdata  = '0;
        ram_we     = 1'b0;
        host_issue = 1'b0;
        if (rst_n) begin
            case (stype)
                CPU_RD: ram_addr = cpu_addr_r;
                CPU_WR: begin
                    if (cpu_we) begin
                        ram_addr  = cpu_addr_w;
                        ram_wdata = cpu_data_o;
                        ram_we    = 1'b1;
                    end
                end
                default: begin
                    if (host_req && !ack_p1) begin
                        host_issue = 1'b1;
                        ram_addr   = host_addr;
                        if (host_we) begin
                            ram_wdata = host_wdata;
                            ram_we    = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Stage p1: RAM data returns one clock after issue.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            ack_p1     <= 1'b0;
            ack_rd_p1  <= 1'b0;
            rdata_p1   <= '0;
            cpu_data_i <= '0;
        end else begin
            ack_p1    <= host_issue;
            ack_rd_p1 <= host_issue && !host_we;
            if (ack_p1 && ack_rd_p1)
                rdata_p1 <= ram_rdata;
            if (stype == CPU_WR)
                cpu_data_i <= ram_rdata;
        end
    end

    assign host_ack   = rst_n && ack_p1;
    // Read data is forwarded during the ack cycle and held afterwards.
    assign host_rdata = (host_ack && ack_rd_p1) ? ram_rdata : rdata_p1;

endmodule

// File: tb/tb_gigatron_mem_arbiter.sv
// Directed self-checking bench for gigatron_mem_arbiter with a behavioural
// synchronous 64K x 8 RAM attached to the arbiter's RAM port.
module tb_gigatron_mem_arbiter;

    localparam int SLOTS = 4;
    localparam int AW    = 16;

    logic          clock = 1'b0;
    logic          rst_n;
    logic [AW-1:0] cpu_addr_r, cpu_addr_w;
    logic [7:0]    cpu_data_o;
    logic          cpu_we;
    logic [7:0]    cpu_data_i;
    logic          cpu_ce;
    logic          host_req, host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_ack;
    logic [7:0]    host_rdata;
    logic          host_hold, cpu_halted;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic          ram_we;
    logic [7:0]    ram_rdata;

    logic [7:0] mem [0:65535];
    int checks = 0;
    int errors = 0;
    int tslot = 0;
    int we_count = 0;
    int ack_count = 0;

    always #5 clock = ~clock;

    gigatron_mem_arbiter #(.SLOTS(SLOTS), .AW(AW)) dut (
        .clock(clock), .rst_n(rst_n),
        .cpu_addr_r(cpu_addr_r), .cpu_addr_w(cpu_addr_w), .cpu_data_o(cpu_data_o),
        .cpu_we(cpu_we), .cpu_data_i(cpu_data_i), .cpu_ce(cpu_ce),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
        .host_hold(host_hold), .cpu_halted(cpu_halted),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_rdata(ram_rdata)
    );

    // RAM model, expected slot position and event counters.
    always @(posedge clock) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
        if (!rst_n) tslot <= 0;
        else        tslot <= (tslot + 1) % SLOTS;
        if (ram_we)   we_count  <= we_count + 1;
        if (host_ack) ack_count <= ack_count + 1;
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_slot(input int s);
        int n = 0;
        cyc();
        while (tslot != s && n < 2 * SLOTS) begin
            cyc();
            n++;
        end
        if (tslot != s) begin
            $display("FAIL wait_slot: slot %0d not reached, at %0d", s, tslot);
            $fatal(1, "slot wait expired");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; cpu_addr_r = 16'h0010; cpu_addr_w = 16'h0020; cpu_data_o = 8'h3C;
        cpu_we = 1'b1; host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234;
        host_wdata = 8'h77; host_hold = 1'b0;
        repeat (3) cyc();
        #2;
        checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL reset_cpu_ce: got %b want 0", cpu_ce); end
        checks++; if (cpu_data_i !== 8'h00) begin errors++; $display("FAIL reset_cpu_data_i: got %h want 00", cpu_data_i); end
        checks++; if (host_ack !== 1'b0) begin errors++; $display("FAIL reset_host_ack: got %b want 0", host_ack); end
        checks++; if (host_rdata !== 8'h00) begin errors++; $display("FAIL reset_host_rdata: got %h want 00", host_rdata); end
        checks++; if (ram_addr !== 16'h0000) begin errors++; $display("FAIL reset_ram_addr: got %h want 0000", ram_addr); end
        checks++; if (ram_wdata !== 8'h00) begin errors++; $display("FAIL reset_ram_wdata: got %h want 00", ram_wdata); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        checks++; if (cpu_halted !== 1'b0) begin errors++; $display("FAIL reset_cpu_halted: got %b want 0", cpu_halted); end
        cyc();
        rst_n = 1'b1; cpu_we = 1'b0; host_req = 1'b0; host_we = 1'b0;
        #2;
        checks++; if (ram_addr !== 16'h0010) begin errors++; $display("FAIL release_slot0_addr: got %h want 0010", ram_addr); end
        checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL release_slot0_we: got %b want 0", ram_we); end
    endtask

    task automatic test_cpu_read();
        wait_slot(0);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) cyc();
            #2;
            checks++; if (cpu_ce !== 1'(tslot == SLOTS - 1)) begin errors++; $display("FAIL cpu_ce_cadence: slot %0d got %b", tslot, cpu_ce); end
            if (tslot == 0) begin
                checks++; if (ram_addr !== 16'h0010 || ram_we !== 1'b0) begin errors++; $display("FAIL cpu_rd_port: got addr %h we %b want 0010 0", ram_addr, ram_we); end
            end
            if (tslot >= 2) begin
                checks++; if (cpu_data_i !== 8'hA5) begin errors++; $display("FAIL cpu_data_i: slot %0d got %h want a5", tslot, cpu_data_i); end
            end
        end
    endtask

    task automatic test_cpu_store();
        wait_slot(0);
        cpu_addr_w = 16'h0020; cpu_data_o = 8'h3C; cpu_we = 1'b1;
        for (int k = 0; k < SLOTS; k++) begin
            if (k > 0) cyc();
            #2;
            checks++; if (ram_we !== 1'(tslot == 1)) begin errors++; $display("FAIL store_we_slot: slot %0d got %b", tslot, ram_we); end
            if (tslot == 1) begin
                checks++; if (ram_addr !== 16'h0020 || ram_wdata !== 8'h3C) begin errors++; $display("FAIL store_port: got %h/%h want 0020/3c", ram_addr, ram_wdata); end
            end
        end
        cyc();
        cpu_we = 1'b0; cpu_addr_r = 16'h0020;
        cyc(); cyc();
        #2;
        checks++; if (cpu_data_i !== 8'h3C) begin errors++; $display("FAIL store_readback: got %h want 3c", cpu_data_i); end
    endtask

    task automatic test_host_write_read();
        wait_slot(0);
        cpu_addr_r = 16'h0010; cpu_we = 1'b0;
        cyc();
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h1234; host_wdata = 8'h77;
        #2;
        checks++; if (ram_we !== 1'b0 || host_ack !== 1'b0) begin errors++; $display("FAIL host_wait_cpu_slot: got we %b ack %b want 0 0", ram_we, host_ack); end
        cyc(); #2;
        checks++; if (ram_we !== 1'b1 || ram_addr !== 16'h1234 || ram_wdata !== 8'h77) begin errors++; $display("FAIL host_wr_issue: got %b %h %h want 1 1234 77", ram_we, ram_addr, ram_wdata); end
        cyc(); #2;
        checks++; if (host_ack !== 1'b1 || cpu_ce !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL host_wr_ack: got ack %b ce %b we %b want 1 1 0", host_ack, cpu_ce, ram_we); end
        cyc();
        host_we = 1'b0;
        #2;
        checks++; if (host_ack !== 1'b0 || ram_addr !== 16'h0010) begin errors++; $display("FAIL host_rd_slot0: got ack %b addr %h want 0 0010", host_ack, ram_addr); end
        cyc(); cyc(); #2;
        checks++; if (ram_addr !== 16'h1234 || ram_we !== 1'b0) begin errors++; $display("FAIL host_rd_issue: got %h %b want 1234 0", ram_addr, ram_we); end
        cyc(); #2;
        checks++; if (host_ack !== 1'b1 || host_rdata !== 8'h77 || cpu_ce !== 1'b1) begin errors++; $display("FAIL host_rd_ack: got ack %b data %h ce %b want 1 77 1", host_ack, host_rdata, cpu_ce); end
        checks++; if (cpu_data_i !== 8'hA5) begin errors++; $display("FAIL cpu_pre_host: got %h want a5", cpu_data_i); end
        cyc();
        host_req = 1'b0;
        #2;
        checks++; if (host_ack !== 1'b0 || host_rdata !== 8'h77) begin errors++; $display("FAIL host_rdata_hold: got ack %b data %h want 0 77", host_ack, host_rdata); end
    endtask

    task automatic test_back_to_back();
        int base_we, base_ack;
        cyc();
        host_req = 1'b1; host_we = 1'b1; host_addr = 16'h0040; host_wdata = 8'h5A;
        base_we = we_count; base_ack = ack_count;
        cyc(); cyc(); #2;
        checks++; if (host_ack !== 1'b1 || ram_we !== 1'b0) begin errors++; $display("FAIL held_req_ack_cycle: got ack %b we %b want 1 0", host_ack, ram_we); end
        cyc();
        host_req = 1'b0;
        cyc(); cyc(); cyc(); #2;
        checks++; if (we_count - base_we !== 1) begin errors++; $display("FAIL held_req_writes: got %0d want 1", we_count - base_we); end
        checks++; if (ack_count - base_ack !== 1) begin errors++; $display("FAIL held_req_acks: got %0d want 1", ack_count - base_ack); end
    endtask

    task automatic test_halt();
        logic [15:0] exp_addr;
        logic [7:0]  exp_data;
        wait_slot(1);
        host_hold = 1'b1;
        #2;
        checks++; if (cpu_halted !== 1'b0) begin errors++; $display("FAIL halt_early_s1: got %b want 0", cpu_halted); end
        cyc(); cyc(); #2;
        checks++; if (cpu_ce !== 1'b1 || cpu_halted !== 1'b0) begin errors++; $display("FAIL halt_window_done: got ce %b halted %b want 1 0", cpu_ce, cpu_halted); end
        cyc();
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0010;
        #2;
        checks++; if (cpu_halted !== 1'b1 || ram_addr !== 16'h0010 || host_ack !== 1'b0) begin errors++; $display("FAIL halted_issue0: got halted %b addr %h ack %b want 1 0010 0", cpu_halted, ram_addr, host_ack); end
        for (int k = 1; k < 8; k++) begin
            cyc();
            if (k % 2 == 0) host_addr = (k % 4 == 0) ? 16'h0010 : 16'h0040;
            #2;
            checks++; if (cpu_ce !== 1'b0) begin errors++; $display("FAIL halted_ce: k %0d got %b want 0", k, cpu_ce); end
            checks++; if (host_ack !== 1'(k % 2)) begin errors++; $display("FAIL halted_ack_rate: k %0d got %b want %0d", k, host_ack, k % 2); end
            if (k % 2 == 1) begin
                exp_data = ((k - 1) % 4 == 0) ? 8'hA5 : 8'h5A;
                checks++; if (host_rdata !== exp_data) begin errors++; $display("FAIL halted_rdata: k %0d got %h want %h", k, host_rdata, exp_data); end
            end else begin
                exp_addr = (k % 4 == 0) ? 16'h0010 : 16'h0040;
                checks++; if (ram_addr !== exp_addr) begin errors++; $display("FAIL halted_issue_addr: k %0d got %h want %h", k, ram_addr, exp_addr); end
            end
            if (k == 4) begin
                checks++; if (cpu_data_i !== 8'hA5) begin errors++; $display("FAIL halted_cpu_data_hold: got %h want a5", cpu_data_i); end
            end
        end
        cyc();
        host_req = 1'b0; host_hold = 1'b0;
        cyc(); cyc(); cyc(); #2;
        checks++; if (cpu_halted !== 1'b1 || cpu_ce !== 1'b0) begin errors++; $display("FAIL release_boundary: got halted %b ce %b want 1 0", cpu_halted, cpu_ce); end
        for (int k = 1; k <= SLOTS; k++) begin
            cyc(); #2;
            checks++; if (cpu_ce !== 1'(k == SLOTS)) begin errors++; $display("FAIL release_ce: clk %0d got %b", k, cpu_ce); end
            if (k == 1) begin
                checks++; if (cpu_halted !== 1'b0 || ram_addr !== 16'h0010) begin errors++; $display("FAIL release_cpu_rd: got halted %b addr %h want 0 0010", cpu_halted, ram_addr); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        wait_slot(1);
        host_req = 1'b1; host_we = 1'b0; host_addr = 16'h0040;
        cyc(); #2;
        checks++; if (ram_addr !== 16'h0040) begin errors++; $display("FAIL midflight_issue: got %h want 0040", ram_addr); end
        cyc();
        rst_n = 1'b0;
        #2;
        checks++; if (host_ack !== 1'b0 || ram_addr !== 16'h0000 || ram_we !== 1'b0 || cpu_ce !== 1'b0) begin errors++; $display("FAIL midflight_rst_outputs: got ack %b addr %h we %b ce %b", host_ack, ram_addr, ram_we, cpu_ce); end
        cyc(); #2;
        checks++; if (cpu_data_i !== 8'h00 || host_rdata !== 8'h00 || cpu_halted !== 1'b0 || host_ack !== 1'b0) begin errors++; $display("FAIL midflight_rst_state: got %h %h %b %b want 00 00 0 0", cpu_data_i, host_rdata, cpu_halted, host_ack); end
        cyc();
        rst_n = 1'b1; host_req = 1'b0;
        #2;
        checks++; if (ram_addr !== 16'h0010 || host_ack !== 1'b0) begin errors++; $display("FAIL post_rst_slot0: got addr %h ack %b want 0010 0", ram_addr, host_ack); end
        for (int k = 2; k <= SLOTS; k++) begin
            cyc(); #2;
            checks++; if (cpu_ce !== 1'(k == SLOTS) || host_ack !== 1'b0) begin errors++; $display("FAIL post_rst_window: clk %0d got ce %b ack %b", k, cpu_ce, host_ack); end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hA5;
        test_reset();
        test_cpu_read();
        test_cpu_store();
        test_host_write_read();
        test_back_to_back();
        test_halt();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gigatron_mem_arbiter.md
Name: gigatron_mem_arbiter

Overview:
- Shares one synchronous single-port 64K x 8 data RAM between the gigatron CPU and a host requester (loader/debug DMA).
- Splits each CPU instruction into a fixed window of SLOTS clocks: a CPU read slot, a CPU write slot, then host slots.
- Generates the CPU clock-enable (cpu_ce) and can halt the CPU at an instruction boundary, handing every slot to the host.

Parameters:
- SLOTS, 4: clocks per CPU instruction window; legal range 3..8.
- AW, 16: RAM address width.

Ports:
- clock  in  1  system clock
- rst_n  in  1  synchronous reset, active low
- cpu_addr_r  in  AW  CPU read address; stable for the whole window
- cpu_addr_w  in  AW  CPU write address
- cpu_data_o  in  8  CPU write data
- cpu_we  in  1  CPU write request for this instruction
- cpu_data_i  out  8  registered read data to the CPU
- cpu_ce  out  1  one-clock pulse; the CPU advances exactly one instruction per pulse
- host_req  in  1  host request; held high until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  AW  host address
- host_wdata  in  8  host write data
- host_ack  out  1  one-clock completion pulse
- host_rdata  out  8  host read data, valid while host_ack = 1
- host_hold  in  1  request CPU halt
- cpu_halted  out  1  CPU halted, all slots belong to the host
- ram_addr  out  AW  RAM address
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable
- ram_rdata  in  8  RAM read data, one clock after the address is presented

Behaviour:
- Reset, synchronous on rst_n = 0 at a clock edge:
  - slot = 0, halted = 0, issued = 0.
  - All outputs 0: cpu_ce, cpu_data_i, host_ack, host_rdata, ram_addr, ram_wdata, ram_we, cpu_halted.
  - An in-flight host access is abandoned with no ack. The host must re-request.
- Slot counter runs 0..SLOTS-1 and wraps to 0. It runs continuously, halted or not.
- RAM port outputs are combinational from slot and state. Read data is captured on the next clock edge.
- Running window (halted = 0):
  - slot 0: ram_addr = cpu_addr_r, ram_we = 0.
  - slot 1: cpu_data_i <= ram_rdata at the end of the cycle. If cpu_we = 1, drive ram_addr = cpu_addr_w, ram_wdata = cpu_data_o, ram_we = 1. Otherwise the port is idle.
  - slots 2..SLOTS-1: host slots.
  - slot SLOTS-1: cpu_ce = 1 for exactly this clock. cpu_data_i is already valid.
- Halted window (halted = 1): every slot is a host slot and cpu_ce stays 0. cpu_data_i holds its value.
- Host slot rule:
  - Issue when host_req = 1, issued = 0, and host_ack is not asserted this cycle.
  - Issue drives ram_addr = host_addr; if host_we = 1, also drives ram_wdata = host_wdata, ram_we = 1. Sets issued = 1.
  - Next clock: host_ack = 1, host_rdata <= ram_rdata (reads only; writes leave host_rdata unchanged), issued = 0.
  - Issue-to-ack latency is exactly 1 clock.
  - No issue in the ack cycle, so a request still held high is never issued twice.
  - The host may present a new request in the cycle after ack.
  - Throughput: one access per window at SLOTS = 4; one access per 2 clocks when halted.
- Ack may fall in slot 0 of the next window. No conflict: the ack cycle only captures data and does not use the port.
- Halt:
  - host_hold is sampled only at slot SLOTS-1, in the same cycle as cpu_ce when running.
  - halted <= host_hold. cpu_halted = halted.
  - Halt and release therefore take effect only at a window boundary; a partial instruction never occurs.
  - Release resumes at slot 0 with a CPU read.
- Simultaneous events:
  - CPU slots always win over the host.
  - A host_req arriving during slot 0 or 1 waits for the first host slot.
  - A host write and a CPU read of the same address in one window: the CPU sees the pre-host value, because the CPU read precedes the host slots.

Decomposition:
- Shared package gigatron_pkg holds:
  - SLOT_CPU_RD = 0 and SLOT_CPU_WR = 1 constants;
  - the slot-type enum {CPU_RD, CPU_WR, HOST};
  - the AW default.
- One natural sub-module: gigatron_slot_timer, containing the slot counter, cpu_ce generation and the halted register.
- The port mux and host handshake stay in the top module.

Test Plan:
- CPU only, SLOTS = 4, RAM[0x0010] = 0xA5, cpu_addr_r = 0x0010, cpu_we = 0 -> cpu_ce pulses every 4 clocks at slot 3; cpu_data_i = 0xA5 from slot 2 onward.
- CPU store, cpu_addr_w = 0x0020, cpu_data_o = 0x3C, cpu_we = 1 -> ram_we = 1 only in slot 1 with ram_addr = 0x0020; a later read returns 0x3C.
- Host write then read while the CPU runs: write 0x1234 = 0x77, then read 0x1234 -> each is issued in slot 2 and acked in slot 3; host_rdata = 0x77; cpu_ce cadence unchanged.
- Held host_req across the ack cycle with the same address -> exactly one RAM access per request; no duplicate ram_we.
- host_hold raised at slot 1 -> the current window completes with its cpu_ce; cpu_halted = 1 from the next slot 0. Halted back-to-back host reads are acked every 2 clocks with no cpu_ce. Release: first cpu_ce 4 clocks after the boundary.
- rst_n = 0 in the cycle after a host issue -> no host_ack; all outputs 0; slot = 0. After release the first window is a CPU read window.
